// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Build option: define UART_TX_PARITY_EN to add a parity bit to every frame.
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT = 5208;  // 50 MHz / 9600 baud
  localparam int MAX_DATA_BITS    = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Narrower words are zero-extended by the caller, so the parity result is unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART transmitter.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_tx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO, baud counter, frame FSM and shift register.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        parity_odd,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int              CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
  localparam int              FW        = DATA_BITS + 1;
`else
  localparam int              FW        = DATA_BITS;
`endif

  tx_state_t            state;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [FW-1:0]        fifo_wdata;
  logic [FW-1:0]        fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 bit_end;
  logic                 last_stop;
  logic                 pop;

`ifdef UART_TX_PARITY_EN
  logic                     par_bit;
  logic [MAX_DATA_BITS-1:0] pop_word_ext;

  assign fifo_wdata   = {parity_odd, s_data};
  assign pop_word_ext = MAX_DATA_BITS'(fifo_rdata[DATA_BITS-1:0]);
`else
  logic parity_odd_unused;

  assign fifo_wdata        = s_data;
  assign parity_odd_unused = parity_odd;
`endif

  uart_tx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign s_ready   = !fifo_full;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign last_stop = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
  // A new word is taken either from idle or straight out of the final stop bit.
  assign pop       = !fifo_empty && ((state == IDLE) || last_stop);
  assign tx_done   = last_stop;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;

      if (pop) begin
        state   <= START;
        tx      <= 1'b0;
        bit_idx <= '0;
        shift   <= fifo_rdata[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
        par_bit <= calc_parity(pop_word_ext, fifo_rdata[DATA_BITS]);
`endif
      end else begin
        case (state)
          IDLE: tx <= 1'b1;
          START: begin
            if (bit_end) begin
              state   <= DATA;
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= '0;
            end
          end
          DATA: begin
            if (bit_end) begin
              if (bit_idx == DATA_LAST) begin
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                state   <= PARITY;
                tx      <= par_bit;
`else
                state   <= STOP;
                tx      <= 1'b1;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
                tx      <= shift[0];
                shift   <= shift >> 1;
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (bit_end) begin
              state <= STOP;
              tx    <= 1'b1;
            end
          end
`endif
          STOP: begin
            if (bit_end) begin
              if (bit_idx == STOP_LAST) begin
                state <= IDLE;
                tx    <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8N1 and a 7-data/2-stop instance, both with BAUD_DIV=4.
// Honours UART_TX_PARITY_EN so the expected frames track the build.
module tb_uart_tx_param;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB1 = 1 + 8 + P + 1;
  localparam int NB2 = 1 + 7 + P + 2;
  localparam int FR1 = NB1 * BD;
  localparam int FR2 = NB2 * BD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0, parity_odd = 1'b0;
  logic       s_ready, tx, busy, tx_done;
  logic [2:0] fifo_count;
  logic [6:0] s_data2 = '0;
  logic       s_valid2 = 1'b0, parity_odd2 = 1'b0;
  logic       s_ready2, tx2, busy2, tx_done2;
  logic [2:0] fifo_count2;

  logic       sel = 1'b0;
  logic       cap_tx, cap_done, cap_busy;
  logic [2:0] cap_count;

  int checks = 0;
  int errors = 0;

  logic rec_tx   [1024];
  logic rec_done [1024];
  logic rec_busy [1024];

  typedef struct {
    logic       sel;
    logic [8:0] data;
    logic       odd;
    logic       par;  // hand-computed parity bit for this word
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] b2b_word [5] = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33};
  logic       b2b_odd  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       b2b_par  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .STOP_BITS(1), .BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .parity_odd(parity_odd), .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count));

  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2), .BAUD_DIV(BD), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data2), .s_valid(s_valid2), .s_ready(s_ready2),
    .parity_odd(parity_odd2), .tx(tx2), .busy(busy2), .tx_done(tx_done2), .fifo_count(fifo_count2));

  always_comb begin
    cap_tx    = sel ? tx2 : tx;
    cap_done  = sel ? tx_done2 : tx_done;
    cap_busy  = sel ? busy2 : busy;
    cap_count = sel ? fifo_count2 : fifo_count;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] build_frame(input logic [8:0] d, input int nd, input logic par,
                                              input int nstop);
    logic [12:0] f;
    int p;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) f[1+i] = d[i];
    p = 1 + nd;
    if (P == 1) begin
      f[p] = par;
      p++;
    end
    for (int j = 0; j < nstop; j++) f[p+j] = 1'b1;
    return f;
  endfunction

  task automatic send_word(input logic s, input logic [8:0] d, input logic odd);
    @(negedge clk);
    if (!s) begin
      s_data = d[7:0]; parity_odd = odd; s_valid = 1'b1;
    end else begin
      s_data2 = d[6:0]; parity_odd2 = odd; s_valid2 = 1'b1;
    end
    @(negedge clk);
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
    s_data   = ~s_data;
    s_data2  = ~s_data2;
  endtask

  // Waits (bounded) for the start bit, then logs one sample per cycle from its first cycle.
  task automatic record(input int n, output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (cap_tx === 1'b0) break;
      if (waited >= 64) begin
        check("start bit seen", 32'(cap_tx), 32'd0);
        for (int k = 0; k < n; k++) begin
          rec_tx[k] = 1'bx; rec_done[k] = 1'bx; rec_busy[k] = 1'bx;
        end
        return;
      end
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      rec_tx[k]   = cap_tx;
      rec_done[k] = cap_done;
      rec_busy[k] = cap_busy;
    end
  endtask

  task automatic verify_frame(input string tag, input int base, input logic [12:0] exp, input int nb);
    logic [12:0] got;
    int nbusy, nearly;
    got = '1;
    nbusy = 0;
    nearly = 0;
    for (int b = 0; b < nb; b++) got[b] = rec_tx[base + b*BD + BD/2];
    for (int k = base; k < base + nb*BD; k++) begin
      if (rec_busy[k] === 1'b1) nbusy++;
      if (k < base + nb*BD - 1 && rec_done[k] !== 1'b0) nearly++;
    end
    check($sformatf("%s bits", tag), 32'(got), 32'(exp));
    check($sformatf("%s done at end", tag), 32'(rec_done[base + nb*BD - 1]), 32'd1);
    check($sformatf("%s done early", tag), nearly, 0);
    check($sformatf("%s busy", tag), nbusy, nb*BD);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, fr, nb, nd, ns, ndone, nones, nbad;

    vecs[0] = '{1'b0, 9'h041, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 9'h041, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 9'h000, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 9'h0FF, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 9'h080, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 9'h05A, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 9'h001, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 9'h07F, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 9'h02A, 1'b1, 1'b0};

    // Reset held while s_valid toggles: nothing may be queued or sent.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("reset hold %0d", i), 32'({tx, s_ready, busy, tx_done, fifo_count}),
            32'b1100000);
      s_valid  = ~s_valid;
      s_valid2 = ~s_valid2;
    end
    @(negedge clk);
    s_valid  = 1'b0;
    s_valid2 = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("after release", 32'({tx, s_ready, busy, tx_done, fifo_count}), 32'b1100000);

    // Single-word frames from idle.
    for (int i = 0; i < 9; i++) begin
      sel = vecs[i].sel;
      nd  = sel ? 7 : 8;
      ns  = sel ? 2 : 1;
      nb  = sel ? NB2 : NB1;
      fr  = sel ? FR2 : FR1;
      send_word(vecs[i].sel, vecs[i].data, vecs[i].odd);
      check($sformatf("vec%0d count after push", i), 32'({cap_count, cap_tx}), 32'b0011);
      record(fr + 4, w);
      check($sformatf("vec%0d start latency", i), w, 1);
      verify_frame($sformatf("vec%0d", i), 0,
                   build_frame(vecs[i].data, nd, vecs[i].par, ns), nb);
      ndone = 0;
      for (int k = 0; k < fr + 4; k++) if (rec_done[k] === 1'b1) ndone++;
      check($sformatf("vec%0d done pulses", i), ndone, 1);
      check($sformatf("vec%0d idle after", i), 32'({rec_tx[fr+2], rec_busy[fr+2]}), 32'b10);
      if (sel) begin
        nones = 0;
        for (int k = fr - 2*BD; k < fr; k++) if (rec_tx[k] === 1'b1) nones++;
        check($sformatf("vec%0d stop high", i), nones, 2*BD);
      end
    end

    // Back-to-back: five pushes into a 4-deep FIFO, then a refused push while full.
    sel = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check($sformatf("b2b ready %0d", i), 32'(s_ready), 32'd1);
          s_data = b2b_word[i]; parity_odd = b2b_odd[i]; s_valid = 1'b1;
        end
        @(negedge clk);
        check("b2b full ready", 32'(s_ready), 32'd0);
        check("b2b full count", 32'(fifo_count), 32'd4);
        s_data = 8'h99; parity_odd = 1'b1;
        @(negedge clk);
        check("b2b refused push", 32'(fifo_count), 32'd4);
        s_valid = 1'b0;
      end
      record(5*FR1 + 8, w);
    join
    for (int f = 0; f < 5; f++)
      verify_frame($sformatf("b2b frame%0d", f), f*FR1,
                   build_frame({1'b0, b2b_word[f]}, 8, b2b_par[f], 1), NB1);
    ndone = 0;
    for (int k = 0; k < 5*FR1 + 8; k++) if (rec_done[k] === 1'b1) ndone++;
    check("b2b done pulses", ndone, 5);
    check("b2b idle after", 32'({rec_tx[5*FR1+2], rec_busy[5*FR1+2], fifo_count}), 32'b10000);

    // Reset during data bit 3 of 0xC3 with a second word queued.
    send_word(1'b0, 9'h0C3, 1'b0);
    send_word(1'b0, 9'h03C, 1'b0);
    repeat (16) @(negedge clk);
    check("mid-frame before reset", 32'({tx, busy, fifo_count}), 32'b01001);
    #2 rst_n = 1'b0;
    #1;
    check("mid-frame async reset", 32'({tx, busy, fifo_count}), 32'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    nbad = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) nbad++;
    end
    check("no stale frame", nbad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
